// File: rtl/l2dr_req_arb_pkg.sv
// ---------------------------------------------------------------------------
// l2dr_req_arb_pkg
//   Shared types and constants for the L2 / L2TLB directory-request merger.
//   - I_l2todr_req_type : request sent towards the directory
//   - I_drtol2_dack_type: dack returned by the directory
//   - nodeid[0] parity identifies which source a request or dack belongs to
//   NODEID_W lives here, not on the top module, because the struct widths
//   are derived from it.
// ---------------------------------------------------------------------------
package l2dr_req_arb_pkg;

    localparam int NODEID_W = 5;
    localparam int ADDR_W   = 32;
    localparam int CMD_W    = 4;
    localparam int DATA_W   = 32;

    localparam logic L2_NODEID_PARITY    = 1'b0;
    localparam logic L2TLB_NODEID_PARITY = 1'b1;

    typedef struct packed {
        logic [NODEID_W-1:0] nodeid;
        logic [CMD_W-1:0]    cmd;
        logic [ADDR_W-1:0]   addr;
    } I_l2todr_req_type;

    typedef struct packed {
        logic [NODEID_W-1:0] nodeid;
        logic [1:0]          ack;
        logic [DATA_W-1:0]   data;
    } I_drtol2_dack_type;

    // Source currently favoured by the round-robin pointer.
    typedef enum logic {
        SRC_L2  = 1'b0,
        SRC_TLB = 1'b1
    } src_e;

    // Stamp the source parity into nodeid[0]; every other field is untouched.
    function automatic I_l2todr_req_type tag_req(input I_l2todr_req_type req,
                                                 input logic parity);
        I_l2todr_req_type r;
        r           = req;
        r.nodeid[0] = parity;
        return r;
    endfunction

endpackage

// File: rtl/l2dr_req_arb_fflop_fifo.sv
// ---------------------------------------------------------------------------
// fflop_fifo
//   Small synchronous FIFO with registered full/empty flags.
//   Ports:
//     clk, reset  - clock, asynchronous active-high reset
//     push, din   - write request and data (ignored while full)
//     full        - registered full flag (occupancy == DEPTH)
//     pop         - read request (ignored while empty)
//     dout        - head-of-queue data, valid while !empty
//     empty       - registered empty flag
//   A push on a full FIFO is dropped even if a pop happens the same cycle,
//   so the full flag never depends combinationally on the consumer.
// ---------------------------------------------------------------------------
module fflop_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/l2dr_req_arb.sv
// ---------------------------------------------------------------------------
// l2dr_req_arb
//   Merges the L2 and L2TLB directory-request streams into l2todr_req and
//   steers directory dacks back by nodeid parity (even -> L2, odd -> L2TLB).
//
//   Handshake (all channels): a beat transfers on a rising clk edge where
//   valid=1 and retry=0; the producer holds valid and payload while retry=1.
//
//   Ports:
//     clk, reset                          clock, async active-high reset
//     l2_req_valid/retry, l2_req          L2 request in
//     tlb_req_valid/retry, tlb_req        L2TLB request in
//     l2todr_req_valid/retry, l2todr_req  merged request out
//     drtol2_dack_valid/retry, drtol2_dack dack in from directory
//     l2_dack_valid/retry                 dack out to L2
//     tlb_dack_valid/retry                dack out to L2TLB
//     dack_out                            dack payload shared by both targets
//
//   Build option: define L2DR_TLB_PRIO_EN to give the L2TLB FIFO fixed
//   priority over L2 instead of round-robin arbitration.
// ---------------------------------------------------------------------------
module l2dr_req_arb
    import l2dr_req_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              l2_req_valid,
    output logic              l2_req_retry,
    input  I_l2todr_req_type  l2_req,
    input  logic              tlb_req_valid,
    output logic              tlb_req_retry,
    input  I_l2todr_req_type  tlb_req,
    output logic              l2todr_req_valid,
    input  logic              l2todr_req_retry,
    output I_l2todr_req_type  l2todr_req,
    input  logic              drtol2_dack_valid,
    output logic              drtol2_dack_retry,
    input  I_drtol2_dack_type drtol2_dack,
    output logic              l2_dack_valid,
    input  logic              l2_dack_retry,
    output logic              tlb_dack_valid,
    input  logic              tlb_dack_retry,
    output I_drtol2_dack_type dack_out
);

    localparam int REQ_W = $bits(I_l2todr_req_type);

    I_l2todr_req_type l2_head, tlb_head;
    logic             l2_empty, tlb_empty;
    logic             l2_pop, tlb_pop;
    logic             load_en;
    logic             grant_tlb;
    logic             out_valid_q, out_valid_d;
    I_l2todr_req_type out_req_q, out_req_d;
`ifndef L2DR_TLB_PRIO_EN
    src_e             rr_q, rr_d;
`endif

    // ---------------- source buffers ----------------
    fflop_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REQ_W)) u_l2_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (l2_req_valid),
        .din   (tag_req(l2_req, L2_NODEID_PARITY)),
        .full  (l2_req_retry),
        .pop   (l2_pop),
        .dout  (l2_head),
        .empty (l2_empty)
    );

    fflop_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REQ_W)) u_tlb_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tlb_req_valid),
        .din   (tag_req(tlb_req, L2TLB_NODEID_PARITY)),
        .full  (tlb_req_retry),
        .pop   (tlb_pop),
        .dout  (tlb_head),
        .empty (tlb_empty)
    );

    // ---------------- arbiter + output register ----------------
    always_comb begin
        l2_pop      = 1'b0;
        tlb_pop     = 1'b0;
        out_valid_d = out_valid_q;
        out_req_d   = out_req_q;
`ifndef L2DR_TLB_PRIO_EN
        rr_d        = rr_q;
`endif
        // Register is free when empty or when it is handing off this cycle.
        load_en = ~out_valid_q | ~l2todr_req_retry;

`ifdef L2DR_TLB_PRIO_EN
        grant_tlb = ~tlb_empty;
`else
        grant_tlb = ~tlb_empty & (l2_empty | (rr_q == SRC_TLB));
`endif

        if (load_en) begin
            out_valid_d = ~l2_empty | ~tlb_empty;
            if (grant_tlb) begin
                tlb_pop   = 1'b1;
                out_req_d = tlb_head;
            end else if (!l2_empty) begin
                l2_pop    = 1'b1;
                out_req_d = l2_head;
            end
`ifndef L2DR_TLB_PRIO_EN
            // Pointer only rotates on a contested grant.
            if (!l2_empty && !tlb_empty) begin
                rr_d = grant_tlb ? SRC_L2 : SRC_TLB;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_req_q   <= '0;
`ifndef L2DR_TLB_PRIO_EN
            rr_q        <= SRC_L2;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_req_q   <= out_req_d;
`ifndef L2DR_TLB_PRIO_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign l2todr_req_valid = out_valid_q;
    assign l2todr_req       = out_req_q;

    // ---------------- dack steering (no storage) ----------------
    logic dack_to_tlb;
    assign dack_to_tlb       = (drtol2_dack.nodeid[0] == L2TLB_NODEID_PARITY);
    assign l2_dack_valid     = drtol2_dack_valid & ~dack_to_tlb;
    assign tlb_dack_valid    = drtol2_dack_valid & dack_to_tlb;
    assign drtol2_dack_retry = dack_to_tlb ? tlb_dack_retry : l2_dack_retry;
    assign dack_out          = drtol2_dack;

endmodule

// File: tb/tb_l2dr_req_arb.sv
module tb_l2dr_req_arb;
    import l2dr_req_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              l2_req_valid, l2_req_retry;
    I_l2todr_req_type  l2_req;
    logic              tlb_req_valid, tlb_req_retry;
    I_l2todr_req_type  tlb_req;
    logic              l2todr_req_valid, l2todr_req_retry;
    I_l2todr_req_type  l2todr_req;
    logic              drtol2_dack_valid, drtol2_dack_retry;
    I_drtol2_dack_type drtol2_dack;
    logic              l2_dack_valid, l2_dack_retry;
    logic              tlb_dack_valid, tlb_dack_retry;
    I_drtol2_dack_type dack_out;

    l2dr_req_arb #(.FIFO_DEPTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .l2_req_valid      (l2_req_valid),
        .l2_req_retry      (l2_req_retry),
        .l2_req            (l2_req),
        .tlb_req_valid     (tlb_req_valid),
        .tlb_req_retry     (tlb_req_retry),
        .tlb_req           (tlb_req),
        .l2todr_req_valid  (l2todr_req_valid),
        .l2todr_req_retry  (l2todr_req_retry),
        .l2todr_req        (l2todr_req),
        .drtol2_dack_valid (drtol2_dack_valid),
        .drtol2_dack_retry (drtol2_dack_retry),
        .drtol2_dack       (drtol2_dack),
        .l2_dack_valid     (l2_dack_valid),
        .l2_dack_retry     (l2_dack_retry),
        .tlb_dack_valid    (tlb_dack_valid),
        .tlb_dack_retry    (tlb_dack_retry),
        .dack_out          (dack_out)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    I_l2todr_req_type exp_l2_q[$];
    I_l2todr_req_type exp_tlb_q[$];
    logic             out_src_q[$];
    int               out_cnt = 0;
    bit               dack_chk_en = 1'b0;

    // Sampled on the falling edge: everything seen here is what the next
    // rising edge will commit.
    always @(negedge clk) begin
        I_l2todr_req_type r, e;
        logic             t;
        if (!reset) begin
            if (l2_req_valid && !l2_req_retry) begin
                r = l2_req; r.nodeid[0] = 1'b0; exp_l2_q.push_back(r);
            end
            if (tlb_req_valid && !tlb_req_retry) begin
                r = tlb_req; r.nodeid[0] = 1'b1; exp_tlb_q.push_back(r);
            end
            if (l2todr_req_valid && !l2todr_req_retry) begin
                out_cnt++;
                out_src_q.push_back(l2todr_req.nodeid[0]);
                total++;
                if ((l2todr_req.nodeid[0] ? exp_tlb_q.size() : exp_l2_q.size()) == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got %h with no request outstanding for source %0d",
                             l2todr_req, l2todr_req.nodeid[0]);
                end else begin
                    e = l2todr_req.nodeid[0] ? exp_tlb_q.pop_front() : exp_l2_q.pop_front();
                    if (l2todr_req !== e) begin
                        bad++;
                        $display("FAIL sb_payload: got %h expected %h", l2todr_req, e);
                    end
                end
            end
            if (dack_chk_en) begin
                t = drtol2_dack.nodeid[0];
                total++;
                if (l2_dack_valid !== (drtol2_dack_valid && !t) ||
                    tlb_dack_valid !== (drtol2_dack_valid && t) ||
                    drtol2_dack_retry !== (t ? tlb_dack_retry : l2_dack_retry) ||
                    dack_out !== drtol2_dack) begin
                    bad++;
                    $display("FAIL dack_steer: got l2v=%b tlbv=%b retry=%b out=%h for dack v=%b %h l2r=%b tlbr=%b",
                             l2_dack_valid, tlb_dack_valid, drtol2_dack_retry, dack_out,
                             drtol2_dack_valid, drtol2_dack, l2_dack_retry, tlb_dack_retry);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic I_l2todr_req_type rand_req();
        I_l2todr_req_type r;
        r.nodeid = NODEID_W'($urandom);
        r.cmd    = CMD_W'($urandom);
        r.addr   = $urandom;
        return r;
    endfunction

    task automatic send_req(input logic src, input I_l2todr_req_type r);
        int n;
        if (src) begin tlb_req = r; tlb_req_valid = 1'b1; end
        else     begin l2_req  = r; l2_req_valid  = 1'b1; end
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!(src ? tlb_req_retry : l2_req_retry)) break;
        end
        @(posedge clk); #1;
        if (src) tlb_req_valid = 1'b0; else l2_req_valid = 1'b0;
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL send_timeout: src=%0d not accepted, got retry stuck expected accept", src);
        end
    endtask

    task automatic wait_drain();
        int n;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (exp_l2_q.size() == 0 && exp_tlb_q.size() == 0 && !l2todr_req_valid) break;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL drain: got l2 pending=%0d tlb pending=%0d expected 0/0",
                     exp_l2_q.size(), exp_tlb_q.size());
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        l2_req_valid = 1'b0; tlb_req_valid = 1'b0; l2_req = '0; tlb_req = '0;
        l2todr_req_retry = 1'b0;
        drtol2_dack_valid = 1'b0; drtol2_dack = '0;
        l2_dack_retry = 1'b0; tlb_dack_retry = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (l2todr_req_valid !== 1'b0 || l2_req_retry !== 1'b0 || tlb_req_retry !== 1'b0 ||
            l2_dack_valid !== 1'b0 || tlb_dack_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got out_v=%b l2r=%b tlbr=%b l2dv=%b tlbdv=%b expected all 0",
                     l2todr_req_valid, l2_req_retry, tlb_req_retry, l2_dack_valid, tlb_dack_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        I_l2todr_req_type r;
        r = rand_req(); r.addr = 32'h100; r.nodeid = 5'd4;
        send_req(1'b0, r);
        total++;
        if (l2todr_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early: got valid=%b expected 0 right after accept", l2todr_req_valid);
        end
        @(posedge clk); #1;
        total++;
        if (l2todr_req_valid !== 1'b1 || l2todr_req.addr !== 32'h100 || l2todr_req.nodeid !== 5'd4) begin
            bad++;
            $display("FAIL single_out: got v=%b addr=%h nodeid=%0d expected v=1 addr=100 nodeid=4",
                     l2todr_req_valid, l2todr_req.addr, l2todr_req.nodeid);
        end
        total++;
        if (l2_req_retry !== 1'b0 || tlb_req_retry !== 1'b0) begin
            bad++;
            $display("FAIL single_retry: got l2r=%b tlbr=%b expected 0/0", l2_req_retry, tlb_req_retry);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic exp;
        out_src_q.delete();
        fork
            begin for (int i = 0; i < 4; i++) send_req(1'b0, rand_req()); end
            begin for (int i = 0; i < 4; i++) send_req(1'b1, rand_req()); end
        join
        wait_drain();
        total++;
        if (out_src_q.size() != 8) begin
            bad++;
            $display("FAIL b2b_count: got %0d outputs expected 8", out_src_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
`ifdef L2DR_TLB_PRIO_EN
                exp = (i < 4);
`else
                exp = logic'(i % 2);
`endif
                total++;
                if (out_src_q[i] !== exp) begin
                    bad++;
                    $display("FAIL b2b_order[%0d]: got src %b expected %b", i, out_src_q[i], exp);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int acc, start_cnt, n;
        logic took;
        start_cnt = out_cnt;
        acc = 0;
        l2todr_req_retry = 1'b1;
        l2_req = rand_req(); l2_req_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            took = !l2_req_retry;
            if (took) acc++;
            @(posedge clk); #1;
            if (took) l2_req = rand_req();
        end
        total++;
        if (acc != 3) begin
            bad++;
            $display("FAIL bp_accepted: got %0d expected 3", acc);
        end
        total++;
        if (l2_req_retry !== 1'b1 || l2todr_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold: got l2r=%b out_v=%b expected 1/1", l2_req_retry, l2todr_req_valid);
        end
        l2todr_req_retry = 1'b0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!l2_req_retry) break;
        end
        @(posedge clk); #1;
        l2_req_valid = 1'b0;
        wait_drain();
        total++;
        if (out_cnt - start_cnt != 4) begin
            bad++;
            $display("FAIL bp_count: got %0d outputs expected 4", out_cnt - start_cnt);
        end
    endtask

    task automatic test_dack();
        I_drtol2_dack_type d;
        d.nodeid = 5'd7; d.ack = 2'($urandom); d.data = $urandom;
        drtol2_dack = d; drtol2_dack_valid = 1'b1;
        tlb_dack_retry = 1'b1; l2_dack_retry = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (tlb_dack_valid !== 1'b1 || l2_dack_valid !== 1'b0 ||
                drtol2_dack_retry !== 1'b1 || dack_out !== d) begin
                bad++;
                $display("FAIL dack_odd_hold[%0d]: got tlbv=%b l2v=%b retry=%b out=%h expected 1 0 1 %h",
                         c, tlb_dack_valid, l2_dack_valid, drtol2_dack_retry, dack_out, d);
            end
            @(posedge clk); #1;
        end
        tlb_dack_retry = 1'b0;
        @(negedge clk);
        total++;
        if (drtol2_dack_retry !== 1'b0 || tlb_dack_valid !== 1'b1) begin
            bad++;
            $display("FAIL dack_odd_done: got retry=%b tlbv=%b expected 0 1", drtol2_dack_retry, tlb_dack_valid);
        end
        @(posedge clk); #1;
        d.nodeid = 5'd6; d.data = $urandom;
        drtol2_dack = d; l2_dack_retry = 1'b1;
        @(negedge clk);
        total++;
        if (l2_dack_valid !== 1'b1 || tlb_dack_valid !== 1'b0 || drtol2_dack_retry !== 1'b1) begin
            bad++;
            $display("FAIL dack_even: got l2v=%b tlbv=%b retry=%b expected 1 0 1",
                     l2_dack_valid, tlb_dack_valid, drtol2_dack_retry);
        end
        @(posedge clk); #1;
        l2_dack_retry = 1'b0;
        @(posedge clk); #1;
        drtol2_dack_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        int stray;
        l2todr_req_retry = 1'b1;
        l2_req = rand_req(); tlb_req = rand_req();
        l2_req_valid = 1'b1; tlb_req_valid = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (l2_req_retry !== 1'b1 || tlb_req_retry !== 1'b1 || l2todr_req_valid !== 1'b1) begin
            bad++;
            $display("FAIL arst_full: got l2r=%b tlbr=%b out_v=%b expected 1 1 1",
                     l2_req_retry, tlb_req_retry, l2todr_req_valid);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (l2todr_req_valid !== 1'b0 || l2_req_retry !== 1'b0 || tlb_req_retry !== 1'b0) begin
            bad++;
            $display("FAIL arst_async: got out_v=%b l2r=%b tlbr=%b expected 0 0 0 before clk",
                     l2todr_req_valid, l2_req_retry, tlb_req_retry);
        end
        exp_l2_q.delete(); exp_tlb_q.delete();
        l2_req_valid = 1'b0; tlb_req_valid = 1'b0;
        l2todr_req_retry = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (l2todr_req_valid) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL arst_stale: got %0d cycles of stale valid expected 0", stray);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_sink(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            l2todr_req_retry = ($urandom_range(0, 2) == 0);
        end
        l2todr_req_retry = 1'b0;
    endtask

    task automatic run_dack(input int cycles);
        logic acc;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            acc = drtol2_dack_valid && !drtol2_dack_retry;
            @(posedge clk); #1;
            l2_dack_retry  = ($urandom_range(0, 3) == 0);
            tlb_dack_retry = ($urandom_range(0, 3) == 0);
            if (!drtol2_dack_valid || acc) begin
                drtol2_dack_valid  = $urandom_range(0, 1) == 1;
                drtol2_dack.nodeid = NODEID_W'($urandom);
                drtol2_dack.ack    = 2'($urandom);
                drtol2_dack.data   = $urandom;
            end
        end
        drtol2_dack_valid = 1'b0;
        l2_dack_retry = 1'b0; tlb_dack_retry = 1'b0;
    endtask

    task automatic test_random();
        int start_cnt;
        start_cnt = out_cnt;
        dack_chk_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    send_req(1'b0, rand_req());
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
            begin
                for (int i = 0; i < 2000; i++) begin
                    send_req(1'b1, rand_req());
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
            run_sink(10000);
            run_dack(10000);
        join
        wait_drain();
        dack_chk_en = 1'b0;
        total++;
        if (out_cnt - start_cnt != 4000) begin
            bad++;
            $display("FAIL rand_count: got %0d outputs expected 4000", out_cnt - start_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_dack();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
